// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO push-side arbiter: FSM encoding,
// default geometry and the width of requester indices.
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int ID_W          = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// Round-robin picker: returns the first requester with req set, searching
// upward from last+1 and wrapping at NREQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] pick,
  output logic            any
);

  // cand[gi] is the requester visited at search step gi; hit[gi] says it wants the FIFO
  logic [NREQ-1:0][ID_W-1:0] cand;
  logic [NREQ-1:0]           hit;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'((32'(last) + 32'(gi) + 32'd1) % 32'(NREQ));
      assign hit[gi]  = |(req & (NREQ'(1) << cand[gi]));
    end
  endgenerate

  // Earliest search step with a hit wins; scanning downward leaves the lowest step last
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        pick = cand[k];
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin burst arbiter for the push side of the 8-deep FIFO. One owner
// at a time pushes up to MAX_BURST beats; a one-cycle IDLE bubble separates
// bursts while the next owner is picked.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data_in,
  input  logic               fifo_full,
  output logic [NREQ-1:0]    ack,
  output logic               fifo_push,
  output logic [DW-1:0]      fifo_din,
  output logic               owner_vld,
  output logic [ID_W-1:0]    owner_id
);

  state_t          state_reg, state_next;
  logic [ID_W-1:0] owner_reg, owner_next;
  logic [ID_W-1:0] last_reg, last_next;
  logic [3:0]      beats_reg, beats_next;

  logic [ID_W-1:0]         pick;
  logic                    any;
  logic [NREQ-1:0]         owner_sel;
  logic [NREQ-1:0][DW-1:0] masked;
  logic [DW-1:0]           owner_data;
  logic                    req_own;
  logic                    xfer;
  logic                    last_beat;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .last (last_reg),
    .pick (pick),
    .any  (any)
  );

  // One-hot owner decode and per-requester data gating, so only the owner's req/data matter
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
      assign owner_sel[gi] = (owner_reg == ID_W'(gi));
      assign masked[gi]    = owner_sel[gi] ? data_in[gi*DW +: DW] : '0;
    end
  endgenerate

  // OR-reduce the gated data words into the owner's word
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      owner_data = owner_data | masked[k];
    end
  end

  assign req_own   = |(req & owner_sel);
  assign xfer      = (state_reg == BURST) && req_own && !fifo_full;
  // Compare in 5 bits so beats+1 can never wrap before reaching MAX_BURST
  assign last_beat = (({1'b0, beats_reg} + 5'd1) == 5'(MAX_BURST));

  assign owner_vld = (state_reg == BURST);
  assign owner_id  = owner_reg;

  // Next-state logic plus the push-side outputs
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    beats_next = beats_reg;
    ack        = '0;
    fifo_push  = 1'b0;
    fifo_din   = '0;
    case (state_reg)
      IDLE: begin
        if (any) begin
          owner_next = pick;
          beats_next = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          fifo_push  = 1'b1;
          fifo_din   = owner_data;
          ack        = owner_sel;
          beats_next = beats_reg + 4'd1;
          if (last_beat) begin
            state_next = IDLE;
            last_next  = owner_reg;
          end
        end else if (!req_own) begin
          // Owner ran dry (full or not): release so others get a turn
          state_next = IDLE;
          last_next  = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; last resets to NREQ-1 so requester 0 is searched first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= ID_W'(NREQ - 1);
      beats_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      beats_reg <= beats_next;
    end
  end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb: reset, rotation, early release, full
// stall, asynchronous reset mid-burst and a run against an 8-deep FIFO model.
module tb_fifo_push_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        fifo_full;
  logic [3:0]  ack;
  logic        fifo_push;
  logic [7:0]  fifo_din;
  logic        owner_vld;
  logic [2:0]  owner_id;

  int total = 0;
  int bad   = 0;

  int          cnt [4];
  logic [3:0]  ack_last;
  logic        push_last;
  logic [7:0]  din_last;
  logic        integ;
  int          fifo_cnt;
  logic [7:0]  fifo_q [$];

  fifo_push_arb #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .fifo_full (fifo_full),
    .ack       (ack),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .owner_vld (owner_vld),
    .owner_id  (owner_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build_data();
    for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = 8'(i * 16 + cnt[i]);
  endtask

  // One clock cycle: inputs applied just after the rising edge, outputs sampled on the falling edge
  task automatic tick(input logic [3:0] r, input logic f);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (ack_last[i]) cnt[i]++;
    if (integ && push_last && fifo_cnt < 8) begin
      fifo_q.push_back(din_last);
      fifo_cnt++;
    end
    req       = r;
    fifo_full = f | (integ && fifo_cnt == 8);
    build_data();
    @(negedge clk);
    ack_last  = ack;
    push_last = fifo_push;
    din_last  = fifo_din;
    if (fifo_push) $display("push ack=%b din=%h owner=%0d", ack, fifo_din, owner_id);
  endtask

  initial begin
    int pos, idx, pushes;
    rst = 1'b0; req = 4'b1111; fifo_full = 1'b0; integ = 1'b0; fifo_cnt = 0;
    ack_last = '0; push_last = 1'b0; din_last = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    build_data();

    // Reset held with every requester asking
    for (int t = 0; t < 3; t++) begin
      tick(4'b1111, 1'b0);
      chk("rst_push", 32'(fifo_push), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_vld", 32'(owner_vld), 0);
    end
    rst = 1'b1;

    // Rotation: 4 beats per owner, one bubble between bursts
    for (int t = 1; t <= 24; t++) begin
      tick(4'b1111, 1'b0);
      pos = (t - 1) % 5;
      idx = ((t - 1) / 5) % 4;
      if (pos == 4) begin
        chk("rot_bubble_push", 32'(fifo_push), 0);
        chk("rot_bubble_vld", 32'(owner_vld), 0);
      end else begin
        chk("rot_ack", 32'(ack), 32'(1 << idx));
        chk("rot_din", 32'(fifo_din), 32'(idx * 16 + ((t - 1) / 20) * 4 + pos));
        chk("rot_id", 32'(owner_id), 32'(idx));
      end
    end

    // Early release by requester 2 after two beats
    tick(4'b0100, 1'b0); chk("er_idle_push", 32'(fifo_push), 0); chk("er_idle_vld", 32'(owner_vld), 0);
    tick(4'b0100, 1'b0); chk("er_b1_ack", 32'(ack), 32'h4); chk("er_b1_din", 32'(fifo_din), 32'h24);
    chk("er_b1_id", 32'(owner_id), 2);
    tick(4'b0100, 1'b0); chk("er_b2_ack", 32'(ack), 32'h4); chk("er_b2_din", 32'(fifo_din), 32'h25);
    tick(4'b0000, 1'b0); chk("er_drop_push", 32'(fifo_push), 0); chk("er_drop_vld", 32'(owner_vld), 1);
    // last=2, so the search starts at 3: requester 3 is ahead of requester 1
    tick(4'b1010, 1'b0); chk("er_idle2_vld", 32'(owner_vld), 0);
    tick(4'b0010, 1'b0); chk("er_pick3_id", 32'(owner_id), 3); chk("er_pick3_push", 32'(fifo_push), 0);
    tick(4'b0010, 1'b0); chk("er_idle3_vld", 32'(owner_vld), 0);
    tick(4'b0010, 1'b0); chk("er_pick1_id", 32'(owner_id), 1); chk("er_pick1_din", 32'(fifo_din), 32'h14);

    // Full stall in requester 1's burst after beat 2
    tick(4'b0010, 1'b0); chk("st_b2_din", 32'(fifo_din), 32'h15);
    for (int t = 0; t < 3; t++) begin
      tick(4'b0010, 1'b1);
      chk("st_push", 32'(fifo_push), 0);
      chk("st_ack", 32'(ack), 0);
      chk("st_id", 32'(owner_id), 1);
      chk("st_vld", 32'(owner_vld), 1);
    end
    tick(4'b0010, 1'b0); chk("st_b3_din", 32'(fifo_din), 32'h16); chk("st_b3_ack", 32'(ack), 32'h2);
    tick(4'b0010, 1'b0); chk("st_b4_din", 32'(fifo_din), 32'h17);
    tick(4'b1000, 1'b0); chk("st_end_vld", 32'(owner_vld), 0); chk("st_end_push", 32'(fifo_push), 0);

    // Asynchronous reset during requester 3's second beat
    tick(4'b1000, 1'b0); chk("mr_b1_id", 32'(owner_id), 3); chk("mr_b1_din", 32'(fifo_din), 32'h34);
    tick(4'b1000, 1'b0); chk("mr_b2_push", 32'(fifo_push), 1); chk("mr_b2_din", 32'(fifo_din), 32'h35);
    #2;
    rst = 1'b0;
    req = 4'b1111;
    #1;
    chk("mr_push", 32'(fifo_push), 0);
    chk("mr_ack", 32'(ack), 0);
    chk("mr_vld", 32'(owner_vld), 0);
    chk("mr_din", 32'(fifo_din), 0);
    ack_last = '0; push_last = 1'b0;
    #1;
    rst = 1'b1;
    tick(4'b1111, 1'b0); chk("mr_after_id", 32'(owner_id), 0); chk("mr_after_ack", 32'(ack), 32'h1);
    chk("mr_after_din", 32'(fifo_din), 32'h08);

    // Integration: 8-deep FIFO, no pops, all requesters active
    rst = 1'b0; integ = 1'b1; fifo_cnt = 0; fifo_q.delete();
    ack_last = '0; push_last = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    tick(4'b1111, 1'b0);
    rst = 1'b1;
    pushes = 0;
    for (int t = 0; t < 20; t++) begin
      tick(4'b1111, 1'b0);
      if (fifo_push) pushes++;
      chk("in_push_full", 32'(fifo_push & fifo_full), 0);
    end
    chk("in_pushes", 32'(pushes), 8);
    chk("in_depth", 32'(fifo_q.size()), 8);
    chk("in_full", 32'(fifo_full), 1);
    chk("in_held", 32'(fifo_push), 0);
    for (int k = 0; k < 8 && k < fifo_q.size(); k++) begin
      chk($sformatf("in_q%0d", k), 32'(fifo_q[k]), 32'((k / 4) * 16 + (k % 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
